genius_playback: RTL and testbench
==================================

Name: genius_playback

Overview:
- Playback controller for the Genius (Simon) game.
- Sits directly downstream of the sequence store; it also drives the store's index input.
- On a play request it steps the index from 0 to the current level, fetches each 2-bit colour and lights the matching one-hot LED for a fixed on-time, followed by a dark gap.
- When the whole pattern has been shown, it pulses done so the player-input stage can take over.

Parameters:
- ON_CYCLES, 4: clock cycles each colour's LED stays lit (≥1).
- OFF_CYCLES, 2: clock cycles of dark gap after each colour (≥1).
- IDX_W, 4: width of the sequence index and of level.
- TMR_W, 8: width of the internal phase timer; must hold max(ON_CYCLES, OFF_CYCLES).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- play  in  1  start request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- level  in  IDX_W  index of the last element to show (0..15, i.e. 1..16 elements); sampled on the play edge.
- current_number  in  2  colour from the sequence store; registered there, valid 1 clk after sequence_count changes.
- sequence_count  out  IDX_W  index driven to the sequence store.
- led  out  3  one-hot colour drive: 0→001, 1→010, 2→100, 3→000.
- busy  out  1  high in FETCH, SHOW, GAP.
- done  out  1  single-cycle pulse when playback completes normally.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sequence_count=0, led=000, busy=0, done=0, timer=0, level register=0.
  - Outputs take these values immediately on assertion, mid-operation included.
- States: IDLE, FETCH, SHOW, GAP, DONE.
- IDLE:
  - play=1 at edge T0 → latch level, sequence_count←0, timer←0, go to FETCH.
  - play=0 → hold; sequence_count keeps its last value.
- FETCH: lasts exactly 2 cycles.
  - Cycle 1: the store samples the new index.
  - Cycle 2: current_number is valid.
  - On the edge leaving FETCH: led←decode(current_number), timer←0, go to SHOW.
- SHOW: lasts ON_CYCLES cycles with led held.
  - On exit: led←000, timer←0, go to GAP.
- GAP: lasts OFF_CYCLES cycles with led=000.
  - On exit, if sequence_count==latched level → DONE.
  - Otherwise sequence_count←sequence_count+1 → FETCH.
  - No wrap: level=15 ends at index 15 and never increments past it.
- DONE: one cycle, done=1, busy=0, then IDLE.
- Per-element period is 2+ON_CYCLES+OFF_CYCLES cycles (8 with defaults). Total for level L is (L+1)·8 busy cycles plus 1 DONE cycle.
- Latency with defaults, measured from the play edge T0:
  - LED lit in cycles T0+2..T0+5.
  - First gap in T0+6..T0+7.
- Value 3 on current_number: led=000 for the SHOW period. Timing is unchanged and no error is flagged.
- play while busy or in DONE: ignored. level changes while busy: ignored, because the latched copy is used.
- abort:
  - Has priority over every transition, including simultaneous play in IDLE.
  - Next state IDLE, led=000, busy=0, no done pulse; sequence_count holds.
- Timer: a single up-counter cleared on every state entry and compared against (phase length − 1).

Decomposition:
- Package genius_pkg holds:
  - state enum (IDLE, FETCH, SHOW, GAP, DONE);
  - colour codes COLOR_0..COLOR_2;
  - LED one-hot constants LED_0=001, LED_1=010, LED_2=100, LED_OFF=000;
  - decode function colour→led.
- One sub-module, genius_phase_timer: a TMR_W counter with clear input and a terminal-count compare output. The FSM, index counter and LED register stay in genius_playback.

Test Plan:
- The bench models the sequence store as a 1-cycle registered lookup holding 2,1,0,1,0,2,…
- Reset: assert rst_n=0 mid-SHOW at level 3 → led=000, busy=0, done=0, sequence_count=0 immediately. After release the block stays IDLE until play.
- Level 0: play at T0 → led=100 in T0+2..T0+5, 000 in T0+6..T0+7, done=1 only in T0+8, IDLE at T0+9.
- Level 2: play → led pattern 100, 010, 001, each for 4 cycles with 2-cycle gaps; sequence_count steps 0,1,2; done at T0+24.
- Busy/ignore: play pulsed at T0+10, and level changed to 5 at T0+12, during a level-1 run → exactly 2 colours shown, done at T0+16, no restart.
- Abort: abort=1 during SHOW of index 1 → next cycle IDLE, led=000, busy=0, no done pulse. A new play restarts from index 0.
- Boundaries:
  - level=15: 16 colours shown, done at T0+128, sequence_count ends at 15.
  - Store forced to output 3 → led=000 for that element's SHOW and timing unchanged.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius playback slice: FSM states,
// colour codes and the colour-to-LED one-hot decode.
package genius_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHOW,
        GAP,
        DONE
    } state_e;

    localparam logic [1:0] COLOR_0 = 2'd0;
    localparam logic [1:0] COLOR_1 = 2'd1;
    localparam logic [1:0] COLOR_2 = 2'd2;

    localparam logic [2:0] LED_0   = 3'b001;
    localparam logic [2:0] LED_1   = 3'b010;
    localparam logic [2:0] LED_2   = 3'b100;
    localparam logic [2:0] LED_OFF = 3'b000;

    // Code 3 is not a colour and leaves all LEDs dark.
    function automatic logic [2:0] decode_led(input logic [1:0] colour);
        case (colour)
            COLOR_0: decode_led = LED_0;
            COLOR_1: decode_led = LED_1;
            COLOR_2: decode_led = LED_2;
            default: decode_led = LED_OFF;
        endcase
    endfunction

endpackage

// File: rtl/genius_phase_timer.sv
// Phase timer: up-counter with synchronous clear and a terminal-count flag
// that is high while the count equals the supplied limit.
module genius_phase_timer #(
    parameter int TMR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [TMR_W-1:0] limit,
    output logic             tc
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    always_comb begin
        count_d = clear ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == limit);

endmodule

// File: rtl/genius_playback.sv
// Genius playback controller: walks the sequence store from index 0 to the
// latched level, lighting each colour for ON_CYCLES then a dark gap.
module genius_playback
    import genius_pkg::*;
#(
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2,
    parameter int IDX_W      = 4,
    parameter int TMR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             play,
    input  logic             abort,
    input  logic [IDX_W-1:0] level,
    input  logic [1:0]       current_number,
    output logic [IDX_W-1:0] sequence_count,
    output logic [2:0]       led,
    output logic             busy,
    output logic             done
);

    localparam logic [TMR_W-1:0] FETCH_LIM = TMR_W'(1);
    localparam logic [TMR_W-1:0] SHOW_LIM  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LIM   = TMR_W'(OFF_CYCLES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] seq_q, seq_d;
    logic [IDX_W-1:0] lvl_q, lvl_d;
    logic [2:0]       led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tmr_clear;
    logic [TMR_W-1:0] tmr_limit;
    logic             tmr_tc;

    genius_phase_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tmr_clear),
        .limit (tmr_limit),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        lvl_d   = lvl_q;
        led_d   = led_q;

        case (state_q)
            IDLE: begin
                if (play) begin
                    lvl_d   = level;
                    seq_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (tmr_tc) begin
                    led_d   = decode_led(current_number);
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (tmr_tc) begin
                    led_d   = LED_OFF;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tmr_tc) begin
                    if (seq_q == lvl_q) begin
                        state_d = DONE;
                    end else begin
                        seq_d   = seq_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the state logic decided, play included.
        if (abort) begin
            state_d = IDLE;
            led_d   = LED_OFF;
            seq_d   = seq_q;
            lvl_d   = lvl_q;
        end

        busy_d = (state_d == FETCH) || (state_d == SHOW) || (state_d == GAP);
        done_d = (state_d == DONE);

        tmr_clear = (state_d != state_q) || (state_q == IDLE);

        case (state_q)
            FETCH:   tmr_limit = FETCH_LIM;
            SHOW:    tmr_limit = SHOW_LIM;
            GAP:     tmr_limit = GAP_LIM;
            default: tmr_limit = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            seq_q   <= '0;
            lvl_q   <= '0;
            led_q   <= LED_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            lvl_q   <= lvl_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sequence_count = seq_q;
    assign led            = led_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_genius_playback.sv
// Self-checking bench for genius_playback: a registered sequence-store model
// feeds the DUT and a per-cycle expected trace is queued and compared.
module tb_genius_playback;

    typedef struct packed {
        logic [2:0] led;
        logic       busy;
        logic       done;
        logic [3:0] seq;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       play = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] level = '0;
    logic [1:0] current_number;
    logic [3:0] sequence_count;
    logic [2:0] led;
    logic       busy;
    logic       done;

    logic [1:0] mem [16];
    obs_t       exp_q [$];
    int         n_checks = 0;
    int         n_fail = 0;

    genius_playback #(
        .ON_CYCLES  (4),
        .OFF_CYCLES (2),
        .IDX_W      (4),
        .TMR_W      (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .play           (play),
        .abort          (abort),
        .level          (level),
        .current_number (current_number),
        .sequence_count (sequence_count),
        .led            (led),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Sequence store: one-cycle registered lookup.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) current_number <= 2'd0;
        else        current_number <= mem[sequence_count];
    end

    function automatic logic [2:0] model_led(input logic [1:0] c);
        case (c)
            2'd0:    model_led = 3'b001;
            2'd1:    model_led = 3'b010;
            2'd2:    model_led = 3'b100;
            default: model_led = 3'b000;
        endcase
    endfunction

    function automatic obs_t mk(input logic [2:0] l, input logic b, input logic d, input int s);
        obs_t o;
        o.led  = l;
        o.busy = b;
        o.done = d;
        o.seq  = 4'(s);
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.led  = led;
        o.busy = busy;
        o.done = done;
        o.seq  = sequence_count;
        return o;
    endfunction

    task automatic load_pattern();
        for (int i = 0; i < 16; i++) begin
            case (i % 6)
                0: mem[i] = 2'd2;
                1: mem[i] = 2'd1;
                2: mem[i] = 2'd0;
                3: mem[i] = 2'd1;
                4: mem[i] = 2'd0;
                default: mem[i] = 2'd2;
            endcase
        end
    endtask

    // Runs one playback starting at edge T0; cycle c is the cycle after edge T0+c.
    // play_at/lvl_at/abort_at name the edge at which that input is sampled (<0: never).
    task automatic run_play(input string name, input int lvl, input int play_at,
                            input int lvl_at, input int abort_at);
        int   n;
        int   abort_seq;
        obs_t full [$];
        obs_t got;
        obs_t exp;
        for (int i = 0; i <= lvl; i++) begin
            for (int k = 0; k < 2; k++) full.push_back(mk(3'b000, 1'b1, 1'b0, i));
            for (int k = 0; k < 4; k++) full.push_back(mk(model_led(mem[i]), 1'b1, 1'b0, i));
            for (int k = 0; k < 2; k++) full.push_back(mk(3'b000, 1'b1, 1'b0, i));
        end
        full.push_back(mk(3'b000, 1'b0, 1'b1, lvl));
        for (int k = 0; k < 2; k++) full.push_back(mk(3'b000, 1'b0, 1'b0, lvl));
        if (abort_at >= 0) begin
            abort_seq = int'(full[abort_at - 1].seq);
            for (int c = 0; c < abort_at; c++) exp_q.push_back(full[c]);
            for (int k = 0; k < 2; k++) exp_q.push_back(mk(3'b000, 1'b0, 1'b0, abort_seq));
        end else begin
            for (int c = 0; c < full.size(); c++) exp_q.push_back(full[c]);
        end
        n = exp_q.size();

        @(negedge clk);
        level = 4'(lvl);
        play  = 1'b1;
        @(posedge clk);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            got = sample();
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s cycle T0+%0d: led=%b busy=%b done=%b seq=%0d, expected led=%b busy=%b done=%b seq=%0d",
                         name, c, got.led, got.busy, got.done, got.seq,
                         exp.led, exp.busy, exp.done, exp.seq);
            end
            play  = (c + 1 == play_at);
            abort = (c + 1 == abort_at);
            if (c + 1 == lvl_at) level = 4'd5;
        end
        play  = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_zero(input string name);
        obs_t got;
        got = sample();
        n_checks++;
        if (got !== mk(3'b000, 1'b0, 1'b0, 0)) begin
            n_fail++;
            $display("FAIL %s: led=%b busy=%b done=%b seq=%0d, expected all zero",
                     name, got.led, got.busy, got.done, got.seq);
        end
    endtask

    task automatic test_reset();
        #1 check_zero("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_zero("idle_after_reset");
        end
        // Start a level-3 run and reset in the middle of the first SHOW.
        level = 4'd3;
        play  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        play = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (led !== 3'b100 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL show_before_reset: led=%b busy=%b, expected led=100 busy=1", led, busy);
        end
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset_mid_show");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_zero("idle_after_mid_reset");
        end
    endtask

    task automatic test_level0();
        run_play("level0", 0, -1, -1, -1);
    endtask

    task automatic test_level2();
        run_play("level2", 2, -1, -1, -1);
    endtask

    task automatic test_busy_ignore();
        run_play("busy_ignore", 1, 10, 12, -1);
    endtask

    task automatic test_abort();
        run_play("abort_show_idx1", 3, -1, -1, 12);
        run_play("restart_after_abort", 1, -1, -1, -1);
    endtask

    task automatic test_level15();
        run_play("level15", 15, -1, -1, -1);
    endtask

    task automatic test_colour3();
        mem[1] = 2'd3;
        run_play("colour3", 2, -1, -1, -1);
        load_pattern();
    endtask

    initial begin
        load_pattern();
        test_reset();
        test_level0();
        test_level2();
        test_busy_ignore();
        test_abort();
        test_level15();
        test_colour3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
